flash_spi_arbiter: RTL and testbench

Shares the single byte-level SPI master and the flash chip select between several transaction-level requesters. Requester 0 is the boot sequencer; higher indices are runtime flash readers. The block grants the SPI engine to one requester for a whole flash transaction, holds `flash_csb_o` low for the full transaction, and routes that requester's byte starts and completions. Between transactions it enforces a minimum chip-select-high gap and rotates priority round-robin.

---
 rtl/flash_arb_pkg.sv | 31 +++
 rtl/flash_spi_arbiter_rr_pick.sv | 43 ++++
 rtl/flash_spi_arbiter.sv | 161 ++++++++++++++++
 tb/tb_flash_spi_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
//------------------------------------------------------------------------------
// flash_arb_pkg
// Shared types and constants for the flash SPI arbiter and its requesters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package flash_arb_pkg;

   // Arbiter state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } arb_state_t;

   // Flash command opcodes used by the boot sequencer and readers
   localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
   localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] FLASH_CMD_RDSR      = 8'h05;
   localparam logic [7:0] FLASH_CMD_RDID      = 8'h9F;

   // Round-robin successor of idx, wrapping modulo n
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/flash_spi_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: first eligible index at or after the
// pointer, wrapping modulo N. Returns a one-hot winner and its index.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] eligible,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] winner,
   output logic [W-1:0] idx,
   output logic         valid
);

   int cand;

   // Scan from the pointer upward, first eligible candidate wins
   always_comb begin
      winner = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = 0;
      for (int i = 0; i < N; i++) begin
         cand = int'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!valid && eligible[cand]) begin
            valid        = 1'b1;
            winner[cand] = 1'b1;
            idx          = W'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/flash_spi_arbiter.sv
//------------------------------------------------------------------------------
// flash_spi_arbiter
// Grants the shared byte-level SPI master and flash chip select to one
// requester per transaction, enforces a chip-select-high gap between
// transactions and rotates priority round-robin.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flash_spi_arbiter
   import flash_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int CS_HIGH_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 boot_lock_i,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ-1:0]   start_i,
   input  logic [8*NUM_REQ-1:0] out_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [NUM_REQ-1:0]   done_o,
   output logic [7:0]           in_o,
   output logic                 spi_start_o,
   output logic [7:0]           spi_out_o,
   input  logic [7:0]           spi_in_i,
   input  logic                 spi_done_i,
   input  logic                 spi_busy_i,
   output logic                 flash_csb_o
);

   localparam int         IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0] GAP_LOAD = 4'(CS_HIGH_CYCLES - 1);

   arb_state_t          state_q;
   logic [IDXW-1:0]     owner_q;
   logic [IDXW-1:0]     ptr_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic                csb_q;
   logic [3:0]          gap_cnt_q;

   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  pick_onehot;
   logic [IDXW-1:0]     pick_idx;
   logic                pick_valid;

   logic                owner_req;
   logic                owner_start;
   logic [7:0]          owner_byte;

   // Boot lock restricts eligibility to the boot sequencer
   always_comb begin
      eligible = req_i;
      if (boot_lock_i) begin
         eligible[NUM_REQ-1:1] = '0;
      end
   end

   rr_pick #(
      .N (NUM_REQ),
      .W (IDXW)
   ) u_rr_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .winner   (pick_onehot),
      .idx      (pick_idx),
      .valid    (pick_valid)
   );

   // Select the owner's request, start and TX byte by the registered index
   always_comb begin
      owner_req   = 1'b0;
      owner_start = 1'b0;
      owner_byte  = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner_q == IDXW'(k)) begin
            owner_req   = req_i[k];
            owner_start = start_i[k];
            owner_byte  = out_i[8*k +: 8];
         end
      end
   end

   // Route starts/bytes to the SPI master and completions back to the owner
   always_comb begin
      spi_start_o = (state_q == OWNED) && owner_start && !spi_busy_i;
      spi_out_o   = (state_q == OWNED) ? owner_byte : 8'h00;
      done_o      = '0;
      if ((state_q == OWNED) || (state_q == DRAIN)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDXW'(k)) begin
               done_o[k] = spi_done_i;
            end
         end
      end
   end

   assign in_o        = spi_in_i;
   assign gnt_o       = gnt_q;
   assign flash_csb_o = csb_q;

   // Transaction FSM with registered grant and chip select
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         csb_q     <= 1'b1;
         gap_cnt_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= OWNED;
                  owner_q <= pick_idx;
                  gnt_q   <= pick_onehot;
                  csb_q   <= 1'b0;
               end
            end
            OWNED: begin
               if (!owner_req) begin
                  gnt_q <= '0;
                  ptr_q <= IDXW'(rr_next(32'(owner_q), NUM_REQ));
                  // A byte in flight (or launched this cycle) keeps csb low
                  if (spi_busy_i || spi_start_o) begin
                     state_q <= DRAIN;
                  end else begin
                     state_q   <= GAP;
                     csb_q     <= 1'b1;
                     gap_cnt_q <= GAP_LOAD;
                  end
               end
            end
            DRAIN: begin
               if (spi_done_i) begin
                  state_q   <= GAP;
                  csb_q     <= 1'b1;
                  gap_cnt_q <= GAP_LOAD;
               end
            end
            GAP: begin
               if (gap_cnt_q == 4'd0) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               csb_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_flash_spi_arbiter.sv
//------------------------------------------------------------------------------
// tb_flash_spi_arbiter
// Directed self-checking bench for flash_spi_arbiter with a small SPI master
// model (3 busy cycles, then a one-cycle done with the queued RX byte).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_flash_spi_arbiter;
   import flash_arb_pkg::*;

   localparam int NREQ = 2;
   localparam int CSH  = 2;

   logic              clk_i       = 1'b0;
   logic              reset_ni    = 1'b0;
   logic              boot_lock_i = 1'b0;
   logic [NREQ-1:0]   req_i       = '0;
   logic [NREQ-1:0]   start_i     = '0;
   logic [8*NREQ-1:0] out_i       = '0;
   logic [NREQ-1:0]   gnt_o;
   logic [NREQ-1:0]   done_o;
   logic [7:0]        in_o;
   logic              spi_start_o;
   logic [7:0]        spi_out_o;
   logic [7:0]        spi_in_i    = 8'h00;
   logic              spi_done_i  = 1'b0;
   logic              spi_busy_i  = 1'b0;
   logic              flash_csb_o;

   logic [1:0]        model_cnt   = 2'd0;
   logic [7:0]        rx_next     = 8'h00;
   int                start_count = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   flash_spi_arbiter #(
      .NUM_REQ        (NREQ),
      .CS_HIGH_CYCLES (CSH)
   ) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .boot_lock_i (boot_lock_i),
      .req_i       (req_i),
      .start_i     (start_i),
      .out_i       (out_i),
      .gnt_o       (gnt_o),
      .done_o      (done_o),
      .in_o        (in_o),
      .spi_start_o (spi_start_o),
      .spi_out_o   (spi_out_o),
      .spi_in_i    (spi_in_i),
      .spi_done_i  (spi_done_i),
      .spi_busy_i  (spi_busy_i),
      .flash_csb_o (flash_csb_o)
   );

   // SPI master model: accept a start when idle, busy 3 cycles, then done
   always @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         spi_busy_i <= 1'b0;
         spi_done_i <= 1'b0;
         model_cnt  <= 2'd0;
      end else begin
         spi_done_i <= 1'b0;
         if (spi_busy_i) begin
            if (model_cnt == 2'd0) begin
               spi_busy_i <= 1'b0;
               spi_done_i <= 1'b1;
               spi_in_i   <= rx_next;
            end else begin
               model_cnt <= model_cnt - 2'd1;
            end
         end else if (spi_start_o) begin
            spi_busy_i  <= 1'b1;
            model_cnt   <= 2'd2;
            start_count <= start_count + 1;
         end
      end
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset;
      reset_ni    = 1'b0;
      req_i       = '0;
      start_i     = '0;
      out_i       = '0;
      boot_lock_i = 1'b0;
      repeat (2) tick;
      reset_ni = 1'b1;
      tick;
   endtask

   // Stimulus only: launch one byte for requester k and wait for its done
   task automatic do_byte(input int k, input logic [7:0] tx, input logic [7:0] rx,
                          output logic start_seen, output logic done_seen,
                          output logic [NREQ-1:0] done_val, output logic [7:0] in_val);
      int n;
      rx_next          = rx;
      out_i[8*k +: 8]  = tx;
      start_i[k]       = 1'b1;
      #1;
      start_seen = spi_start_o;
      tick;
      start_i[k] = 1'b0;
      n = 0;
      while (!spi_done_i && n < 20) begin
         tick;
         n++;
      end
      done_seen = spi_done_i;
      done_val  = done_o;
      in_val    = in_o;
      tick;
   endtask

   task automatic test_reset;
      apply_reset;
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
      checks++; if (flash_csb_o !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b expected 1", flash_csb_o); end
      checks++; if (done_o !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done_o); end
      checks++; if (spi_start_o !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b expected 0", spi_start_o); end
      checks++; if (spi_out_o !== 8'h00) begin errors++; $display("FAIL reset_spi_out: got %h expected 00", spi_out_o); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
   endtask

   task automatic test_single_owner;
      logic st, dn;
      logic [NREQ-1:0] dv;
      logic [7:0] iv;
      logic [7:0] rx;
      req_i = 2'b01;
      #1;
      checks++; if (flash_csb_o !== 1'b1) begin errors++; $display("FAIL single_csb_before: got %b expected 1", flash_csb_o); end
      tick;
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt_o); end
      checks++; if (flash_csb_o !== 1'b0) begin errors++; $display("FAIL single_csb_low: got %b expected 0", flash_csb_o); end
      for (int b = 0; b < 4; b++) begin
         rx = 8'hA1 + 8'(b);
         do_byte(0, 8'h30 + 8'(b), rx, st, dn, dv, iv);
         checks++; if (st !== 1'b1) begin errors++; $display("FAIL single_start%0d: got %b expected 1", b, st); end
         checks++; if (dn !== 1'b1 || dv !== 2'b01) begin errors++; $display("FAIL single_done%0d: got %b/%b expected 1/01", b, dn, dv); end
         checks++; if (iv !== rx) begin errors++; $display("FAIL single_in%0d: got %h expected %h", b, iv, rx); end
      end
      checks++; if (flash_csb_o !== 1'b0) begin errors++; $display("FAIL single_csb_held: got %b expected 0", flash_csb_o); end
      req_i = 2'b00;
      tick;
      checks++; if (flash_csb_o !== 1'b1 || gnt_o !== 2'b00) begin errors++; $display("FAIL single_release: got csb %b gnt %b expected 1 00", flash_csb_o, gnt_o); end
      tick;
      checks++; if (flash_csb_o !== 1'b1) begin errors++; $display("FAIL single_gap2: got %b expected 1", flash_csb_o); end
      tick;
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL single_idle: got %0d expected IDLE", dut.state_q); end
   endtask

   task automatic test_round_robin;
      int n;
      apply_reset;
      req_i = 2'b11;
      tick;
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", gnt_o); end
      req_i = 2'b10;
      tick;
      req_i = 2'b11;
      n = 0;
      while (flash_csb_o && n < 20) begin n++; tick; end
      checks++; if (n !== CSH + 1) begin errors++; $display("FAIL rr_gap1: got %0d expected %0d", n, CSH + 1); end
      checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", gnt_o); end
      req_i = 2'b01;
      tick;
      req_i = 2'b11;
      n = 0;
      while (flash_csb_o && n < 20) begin n++; tick; end
      checks++; if (n !== CSH + 1) begin errors++; $display("FAIL rr_gap2: got %0d expected %0d", n, CSH + 1); end
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_third: got %b expected 01", gnt_o); end
      req_i = 2'b00;
      repeat (CSH + 2) tick;
   endtask

   task automatic test_boot_lock;
      int bad;
      boot_lock_i = 1'b1;
      req_i       = 2'b10;
      bad         = 0;
      repeat (50) begin
         tick;
         if (gnt_o !== 2'b00) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL lock_hold: got %0d grant cycles expected 0", bad); end
      boot_lock_i = 1'b0;
      tick;
      checks++; if (gnt_o !== 2'b10 || flash_csb_o !== 1'b0) begin errors++; $display("FAIL lock_drop: got gnt %b csb %b expected 10 0", gnt_o, flash_csb_o); end
      req_i = 2'b00;
      repeat (CSH + 2) tick;
   endtask

   task automatic test_release_mid_byte;
      int n, bad;
      logic found;
      req_i = 2'b01;
      tick;
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL drain_gnt: got %b expected 01", gnt_o); end
      rx_next    = 8'hC7;
      out_i[7:0] = 8'h3C;
      start_i[0] = 1'b1;
      #1;
      checks++; if (spi_start_o !== 1'b1 || spi_out_o !== 8'h3C) begin errors++; $display("FAIL drain_start: got %b %h expected 1 3c", spi_start_o, spi_out_o); end
      tick;
      start_i[0] = 1'b0;
      req_i      = 2'b00;
      tick;
      checks++; if (flash_csb_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL drain_enter: got csb %b gnt %b expected 0 00", flash_csb_o, gnt_o); end
      start_i[0] = 1'b1;
      #1;
      n = 0; bad = 0; found = 1'b0;
      while (!found && n < 20) begin
         if (spi_start_o) bad++;
         if (flash_csb_o !== 1'b0) bad++;
         if (spi_done_i) begin
            found = 1'b1;
         end else begin
            tick;
            n++;
         end
      end
      checks++; if (!found || done_o !== 2'b01 || in_o !== 8'hC7) begin errors++; $display("FAIL drain_done: got %b %b %h expected 1 01 c7", found, done_o, in_o); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL drain_quiet: got %0d bad cycles expected 0", bad); end
      tick;
      start_i[0] = 1'b0;
      checks++; if (flash_csb_o !== 1'b1) begin errors++; $display("FAIL drain_gap: got %b expected 1", flash_csb_o); end
      repeat (CSH + 1) tick;
   endtask

   task automatic test_filtering;
      int n, s0;
      req_i = 2'b01;
      tick;
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL filt_gnt: got %b expected 01", gnt_o); end
      out_i   = {8'h55, 8'h12};
      start_i = 2'b10;
      #1;
      checks++; if (spi_start_o !== 1'b0) begin errors++; $display("FAIL filt_nonowner_start: got %b expected 0", spi_start_o); end
      checks++; if (spi_out_o !== 8'h12) begin errors++; $display("FAIL filt_nonowner_byte: got %h expected 12", spi_out_o); end
      s0      = start_count;
      start_i = 2'b01;
      #1;
      checks++; if (spi_start_o !== 1'b1) begin errors++; $display("FAIL filt_owner_start: got %b expected 1", spi_start_o); end
      tick;
      start_i = 2'b01;
      #1;
      checks++; if (spi_start_o !== 1'b0) begin errors++; $display("FAIL filt_busy_start: got %b expected 0", spi_start_o); end
      tick;
      start_i = 2'b00;
      n = 0;
      while (!spi_done_i && n < 20) begin tick; n++; end
      repeat (4) tick;
      checks++; if (start_count - s0 !== 1) begin errors++; $display("FAIL filt_start_count: got %0d expected 1", start_count - s0); end
      req_i = 2'b00;
      repeat (CSH + 2) tick;
   endtask

   task automatic test_async_reset;
      req_i = 2'b01;
      tick;
      checks++; if (gnt_o !== 2'b01 || flash_csb_o !== 1'b0) begin errors++; $display("FAIL arst_pre: got gnt %b csb %b expected 01 0", gnt_o, flash_csb_o); end
      #3;
      reset_ni = 1'b0;
      #1;
      checks++; if (flash_csb_o !== 1'b1 || gnt_o !== 2'b00) begin errors++; $display("FAIL arst_immediate: got csb %b gnt %b expected 1 00", flash_csb_o, gnt_o); end
      req_i = 2'b00;
      repeat (2) tick;
      @(negedge clk_i);
      reset_ni = 1'b1;
      req_i    = 2'b10;
      tick;
      checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL arst_regrant: got %b expected 10", gnt_o); end
      req_i = 2'b00;
      repeat (CSH + 2) tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single_owner;
      test_round_robin;
      test_boot_lock;
      test_release_mid_byte;
      test_filtering;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
